if_stage: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the decode stage.
- Owns the PC register and fetches one instruction at a time from instruction ROM over a request/ready handshake.
- Presents addr/inst/valid to decode through a one-entry output register.
- Supports downstream stall and branch redirect, with discard of an in-flight fetch.

---
 rtl/if_stage.sv | 157 +++++++++++++++
 tb/tb_if_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage feeding the decode stage.
//               Owns the PC and fetches one instruction at a time from the
//               instruction ROM over a request/ready handshake. The fetched
//               instruction is held in a one-entry output register
//               (addr/inst/valid) until decode accepts it. The stage supports
//               downstream stall and branch redirect. A redirect that arrives
//               while a ROM request is still outstanding drops the returning
//               data.
//
// Ports       : clk          - clock, all state updates on the rising edge
//               rst          - synchronous active-high reset
//               stall        - decode cannot accept; hold the output register
//               branch_flag  - single-cycle redirect request
//               branch_addr  - redirect target (low two bits ignored)
//               rom_en       - fetch request to the instruction ROM
//               rom_addr     - fetch address
//               rom_rdata    - fetched instruction, valid when rom_ready=1
//               rom_ready    - ROM completes the current request this cycle
//               addr         - PC of the instruction in the output register
//               inst         - instruction in the output register
//               valid        - output register holds an instruction
//
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'hBFC0_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  branch_flag,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [INST_WIDTH-1:0] rom_rdata,
    input  logic                  rom_ready,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  valid
);

    // ------------------------------------------------------------------
    // Constants and state encoding
    // ------------------------------------------------------------------
    localparam logic [ADDR_WIDTH-1:0] C_PC_STEP    = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] C_ALIGN_MASK = ~ADDR_WIDTH'(3);

    // RUN     : normal fetching
    // DISCARD : a redirect arrived while a request was outstanding; the
    //           request is kept stable until the ROM finishes it, and the
    //           returned data is then thrown away.
    typedef enum logic [0:0] {
        S_RUN     = 1'b0,
        S_DISCARD = 1'b1
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [ADDR_WIDTH-1:0]   r_target;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [INST_WIDTH-1:0]   r_inst;
    logic                    r_valid;

    logic                    w_rom_en;
    logic [ADDR_WIDTH-1:0]   w_branch_tgt;

    // Redirect targets are forced onto a word boundary; there is no
    // misalignment exception.
    assign w_branch_tgt = branch_addr & C_ALIGN_MASK;

    // ------------------------------------------------------------------
    // ROM request
    // ------------------------------------------------------------------
    // In RUN a fetch is requested whenever the output register can take a
    // new instruction in the cycle the ROM answers: it is empty, or it is
    // being drained this cycle. valid can only become 1 through a capture,
    // which ends the request, so the request cannot drop before rom_ready.
    // In DISCARD the old request is held until the ROM completes it.
    always_comb begin
        w_rom_en = 1'b0;
        if (!rst) begin
            w_rom_en = (r_state == S_DISCARD) || !r_valid || !stall;
        end
    end

    assign rom_en   = w_rom_en;
    assign rom_addr = r_pc;

    // ------------------------------------------------------------------
    // PC, redirect tracking and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_RUN;
            r_pc     <= RESET_PC;
            r_target <= '0;
            r_addr   <= '0;
            r_inst   <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (branch_flag) begin
                        // A redirect flushes the output register even if
                        // decode is stalled.
                        r_valid <= 1'b0;
                        if (w_rom_en && !rom_ready) begin
                            // Request outstanding: it must complete at the
                            // old address first, so park the target.
                            r_target <= w_branch_tgt;
                            r_state  <= S_DISCARD;
                        end else begin
                            // No request, or it completes right now: the
                            // returned data is simply not captured.
                            r_pc <= w_branch_tgt;
                        end
                    end else if (w_rom_en && rom_ready) begin
                        r_addr  <= r_pc;
                        r_inst  <= rom_rdata;
                        r_valid <= 1'b1;
                        r_pc    <= r_pc + C_PC_STEP;
                    end else if (r_valid && !stall) begin
                        // Decode took the instruction and nothing replaced it.
                        r_valid <= 1'b0;
                    end
                end

                S_DISCARD: begin
                    r_valid <= 1'b0;
                    if (rom_ready) begin
                        // The new fetch starts next cycle from the most
                        // recent redirect target.
                        r_pc    <= branch_flag ? w_branch_tgt : r_target;
                        r_state <= S_RUN;
                    end else if (branch_flag) begin
                        r_target <= w_branch_tgt;
                    end
                end

                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    assign addr  = r_addr;
    assign inst  = r_inst;
    assign valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Self-checking bench for if_stage. It applies a table of
//               directed vectors, then hand-written sequences for the PC wrap
//               and reset during a pending fetch. It then runs a randomized
//               phase with a variable-latency ROM, which is checked against
//               an instruction-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam int unsigned AW         = 32;
    localparam int unsigned IW         = 32;
    localparam logic [31:0] C_RESET_PC = 32'hBFC0_0000;
    localparam int          C_RAND_CYC = 4000;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          branch_flag;
    logic [AW-1:0] branch_addr;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [IW-1:0] rom_rdata;
    logic          rom_ready;
    logic [AW-1:0] addr;
    logic [IW-1:0] inst;
    logic          valid;

    always #5 clk = ~clk;

    if_stage #(
        .ADDR_WIDTH (AW),
        .INST_WIDTH (IW),
        .RESET_PC   (C_RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .branch_flag (branch_flag),
        .branch_addr (branch_addr),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_rdata   (rom_rdata),
        .rom_ready   (rom_ready),
        .addr        (addr),
        .inst        (inst),
        .valid       (valid)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction content the randomized ROM returns for an address.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] baddr;
        logic        rdy;
        logic [31:0] rdata;
        logic        en_e;
        logic [31:0] ra_e;
        logic [31:0] addr_e;
        logic [31:0] inst_e;
        logic        valid_e;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic b,
                                input logic [31:0] ba, input logic rdy,
                                input logic [31:0] rd, input logic en,
                                input logic [31:0] ra, input logic [31:0] a,
                                input logic [31:0] i, input logic v);
        vec_t t;
        t.rst = r; t.stall = s; t.br = b; t.baddr = ba; t.rdy = rdy; t.rdata = rd;
        t.en_e = en; t.ra_e = ra; t.addr_e = a; t.inst_e = i; t.valid_e = v;
        return t;
    endfunction

    // Drive one cycle's inputs just after a rising edge. Check the request
    // before the next edge, then check the output register just after it.
    task automatic apply(input vec_t t, input string tag);
        rst         = t.rst;
        stall       = t.stall;
        branch_flag = t.br;
        branch_addr = t.baddr;
        rom_ready   = t.rdy;
        rom_rdata   = t.rdata;
        #2;
        check({tag, ".rom_en"},   {31'b0, rom_en}, {31'b0, t.en_e});
        check({tag, ".rom_addr"}, rom_addr, t.ra_e);
        @(posedge clk);
        #1;
        check({tag, ".addr"},  addr, t.addr_e);
        check({tag, ".inst"},  inst, t.inst_e);
        check({tag, ".valid"}, {31'b0, valid}, {31'b0, t.valid_e});
    endtask

    // Reference model state for the randomized phase: what decode should see
    // and which address the next useful fetch must target.
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_inst;
    logic [31:0] exp_next;
    logic        disc;
    logic [31:0] disc_addr;
    int          n_cap;

    initial begin
        rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_addr = '0;
        rom_ready = 1'b0; rom_rdata = '0;
        @(posedge clk);
        #1;

        //            rst s b baddr         rdy rdata         en ra            addr          inst          v
        vecs.push_back(mk(1,0,0,32'h0,        1,32'h0,        0,32'hBFC00000,32'h0,        32'h0,        0));
        vecs.push_back(mk(0,0,0,32'h0,        1,32'h11,       1,32'hBFC00000,32'hBFC00000,32'h11,       1));
        vecs.push_back(mk(0,0,0,32'h0,        1,32'h22,       1,32'hBFC00004,32'hBFC00004,32'h22,       1));
        vecs.push_back(mk(0,0,0,32'h0,        1,32'h34210001, 1,32'hBFC00008,32'hBFC00008,32'h34210001, 1));
        vecs.push_back(mk(0,1,0,32'h0,        1,32'hDEADBEEF, 0,32'hBFC0000C,32'hBFC00008,32'h34210001, 1));
        vecs.push_back(mk(0,1,0,32'h0,        1,32'hDEADBEEF, 0,32'hBFC0000C,32'hBFC00008,32'h34210001, 1));
        vecs.push_back(mk(0,1,0,32'h0,        1,32'hDEADBEEF, 0,32'hBFC0000C,32'hBFC00008,32'h34210001, 1));
        vecs.push_back(mk(0,0,0,32'h0,        1,32'h44,       1,32'hBFC0000C,32'hBFC0000C,32'h44,       1));
        vecs.push_back(mk(0,0,0,32'h0,        0,32'hEEEE,     1,32'hBFC00010,32'hBFC0000C,32'h44,       0));
        vecs.push_back(mk(0,0,0,32'h0,        1,32'h55,       1,32'hBFC00010,32'hBFC00010,32'h55,       1));
        vecs.push_back(mk(0,0,0,32'h0,        0,32'hEEEE,     1,32'hBFC00014,32'hBFC00010,32'h55,       0));
        vecs.push_back(mk(0,0,0,32'h0,        1,32'h66,       1,32'hBFC00014,32'hBFC00014,32'h66,       1));
        vecs.push_back(mk(0,0,1,32'h80000100, 0,32'hEEEE,     1,32'hBFC00018,32'hBFC00014,32'h66,       0));
        vecs.push_back(mk(0,0,0,32'h0,        0,32'hEEEE,     1,32'hBFC00018,32'hBFC00014,32'h66,       0));
        vecs.push_back(mk(0,0,0,32'h0,        1,32'hBAD0,     1,32'hBFC00018,32'hBFC00014,32'h66,       0));
        vecs.push_back(mk(0,0,0,32'h0,        1,32'h77,       1,32'h80000100,32'h80000100,32'h77,       1));
        vecs.push_back(mk(0,0,1,32'h80000103, 1,32'hBAD1,     1,32'h80000104,32'h80000100,32'h77,       0));
        vecs.push_back(mk(0,0,0,32'h0,        1,32'h88,       1,32'h80000100,32'h80000100,32'h88,       1));
        vecs.push_back(mk(0,1,1,32'h00001000, 1,32'hBAD2,     0,32'h80000104,32'h80000100,32'h88,       0));
        vecs.push_back(mk(0,1,0,32'h0,        1,32'h99,       1,32'h00001000,32'h00001000,32'h99,       1));
        vecs.push_back(mk(0,1,0,32'h0,        1,32'hBAD3,     0,32'h00001004,32'h00001000,32'h99,       1));
        vecs.push_back(mk(0,0,0,32'h0,        0,32'hEEEE,     1,32'h00001004,32'h00001000,32'h99,       0));
        vecs.push_back(mk(0,0,1,32'h00002000, 0,32'hEEEE,     1,32'h00001004,32'h00001000,32'h99,       0));
        vecs.push_back(mk(0,0,1,32'h00003000, 0,32'hEEEE,     1,32'h00001004,32'h00001000,32'h99,       0));
        vecs.push_back(mk(0,0,0,32'h0,        1,32'hBAD4,     1,32'h00001004,32'h00001000,32'h99,       0));
        vecs.push_back(mk(0,0,0,32'h0,        1,32'hAA,       1,32'h00003000,32'h00003000,32'hAA,       1));

        for (int k = 0; k < vecs.size(); k++)
            apply(vecs[k], $sformatf("vec%0d", k));

        // PC wrap: redirect to the last word, then fetch across zero.
        apply(mk(0,0,1,32'hFFFFFFFC, 1,32'hBAD5, 1,32'h00003004,32'h00003000,32'hAA, 0), "wrap.br");
        apply(mk(0,0,0,32'h0,        1,32'hC1,   1,32'hFFFFFFFC,32'hFFFFFFFC,32'hC1, 1), "wrap.top");
        apply(mk(0,0,0,32'h0,        1,32'hC2,   1,32'h00000000,32'h00000000,32'hC2, 1), "wrap.zero");

        // Reset while a request is outstanding.
        apply(mk(0,0,0,32'h0,        0,32'hEEEE, 1,32'h00000004,32'h00000000,32'hC2, 0), "rstw.pend");
        apply(mk(1,0,0,32'h0,        0,32'hEEEE, 0,32'h00000004,32'h00000000,32'h0,  0), "rstw.rst");
        apply(mk(0,0,0,32'h0,        0,32'hEEEE, 1,32'hBFC00000,32'h00000000,32'h0,  0), "rstw.req");
        apply(mk(0,0,0,32'h0,        1,32'hD1,   1,32'hBFC00000,32'hBFC00000,32'hD1, 1), "rstw.cap");

        // ---------------- randomized phase ----------------
        m_valid = 1'b0; m_addr = '0; m_inst = '0; exp_next = C_RESET_PC;
        disc = 1'b0; disc_addr = '0; n_cap = 0;
        begin
            int          cnt;
            int          lat;
            logic        r_in, s_in, b_in, rdy_v, e_en, pre_en;
            logic [31:0] ba;
            cnt = 0; lat = 0;
            for (int i = 0; i < C_RAND_CYC; i++) begin
                r_in = (i < 2) || ($urandom_range(0, 199) == 0);
                s_in = ($urandom_range(0, 99) < 30);
                b_in = ($urandom_range(0, 99) < 6);
                ba   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : 32'($urandom);
                rst = r_in; stall = s_in; branch_flag = b_in; branch_addr = ba;
                e_en = !r_in && (disc || !m_valid || !s_in);
                #1;
                // Variable-latency ROM; rom_ready is random (and must be
                // ignored) while no request is active.
                if (rom_en) begin
                    if (cnt == 0) lat = $urandom_range(0, 3);
                    rdy_v = (cnt >= lat);
                end else begin
                    rdy_v = 1'($urandom_range(0, 1));
                end
                rom_ready = rdy_v;
                rom_rdata = (rdy_v && rom_en) ? rom_word(rom_addr) : 32'($urandom);
                #1;
                check("rnd.rom_en", {31'b0, rom_en}, {31'b0, e_en});
                if (e_en)
                    check("rnd.rom_addr", rom_addr, disc ? disc_addr : exp_next);
                pre_en = rom_en;
                @(posedge clk);
                if (!r_in && pre_en && !rdy_v) cnt++;
                else cnt = 0;
                #1;
                if (r_in) begin
                    m_valid = 1'b0; m_addr = '0; m_inst = '0;
                    exp_next = C_RESET_PC; disc = 1'b0;
                end else if (disc) begin
                    m_valid = 1'b0;
                    if (b_in) exp_next = ba & 32'hFFFF_FFFC;
                    if (rdy_v) disc = 1'b0;
                end else if (b_in) begin
                    m_valid = 1'b0;
                    if (e_en && !rdy_v) begin
                        disc      = 1'b1;
                        disc_addr = exp_next;
                    end
                    exp_next = ba & 32'hFFFF_FFFC;
                end else if (e_en && rdy_v) begin
                    m_addr   = exp_next;
                    m_inst   = rom_word(exp_next);
                    m_valid  = 1'b1;
                    exp_next = exp_next + 32'd4;
                    n_cap++;
                end else if (m_valid && !s_in) begin
                    m_valid = 1'b0;
                end
                check("rnd.valid", {31'b0, valid}, {31'b0, m_valid});
                check("rnd.addr", addr, m_addr);
                check("rnd.inst", inst, m_inst);
            end
            check("rnd.progress", {31'b0, (n_cap >= 200)}, 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
